// File: rtl/shreg_burst.sv
// Universal shift register (hold / shift right / shift left / load) with an autonomous burst-shift engine.
// Optional macro SHREG_ROTATE_EN: burst shifts rotate instead of taking fill bits from sin_l/sin_r.
module shreg_burst #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, BURST} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] rem_q;
  logic             bdir_q;
  logic             done_q;
  logic             fill_r_c;
  logic             fill_l_c;

  // Bits shifted in during a burst: wrapped-around data or the serial inputs.
`ifdef SHREG_ROTATE_EN
  assign fill_r_c = data_q[0];
  assign fill_l_c = data_q[WIDTH-1];
`else
  assign fill_r_c = sin_l;
  assign fill_l_c = sin_r;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      bdir_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        BURST: begin
          if (bdir_q) data_q <= {data_q[WIDTH-2:0], fill_l_c};
          else        data_q <= {fill_r_c, data_q[WIDTH-1:1]};
          rem_q <= rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        IDLE: begin
          if (start) begin
            bdir_q <= dir;
            if (count == '0) begin
              done_q <= 1'b1;
            end else begin
              rem_q   <= count;
              state_q <= BURST;
            end
          end else begin
            case (mode)
              2'b01:   data_q <= {sin_l, data_q[WIDTH-1:1]};
              2'b10:   data_q <= {data_q[WIDTH-2:0], sin_r};
              2'b11:   data_q <= din;
              default: data_q <= data_q;
            endcase
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout = data_q;
  assign busy = (state_q == BURST);
  assign done = done_q;

endmodule

// File: tb/tb_shreg_burst.sv
// Self-checking bench for shreg_burst (WIDTH=4, CNT_W=3): per-cycle model compare plus literal checkpoints.
module tb_shreg_burst;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       mode;
  logic [WIDTH-1:0] din;
  logic             sin_l, sin_r, start, dir;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] dout;
  logic             busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  shreg_burst #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .mode(mode), .din(din), .sin_l(sin_l), .sin_r(sin_r),
    .start(start), .dir(dir), .count(count), .dout(dout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: value as an integer, burst as "shifts still owed".
  int m_val   = 0;
  int m_owed  = 0;
  bit m_left  = 1'b0;
  bit m_done  = 1'b0;
  localparam int MASK = (1 << WIDTH) - 1;

  function automatic int shr(input int v, input int fill);
    return ((v >> 1) | (fill << (WIDTH - 1))) & MASK;
  endfunction
  function automatic int shl(input int v, input int fill);
    return ((v << 1) | fill) & MASK;
  endfunction

  always @(posedge clk) begin
    int fill;
    if (reset) begin
      m_val = 0; m_owed = 0; m_left = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_owed > 0) begin
`ifdef SHREG_ROTATE_EN
        fill = m_left ? (m_val >> (WIDTH - 1)) & 1 : m_val & 1;
`else
        fill = m_left ? int'(sin_r) : int'(sin_l);
`endif
        m_val  = m_left ? shl(m_val, fill) : shr(m_val, fill);
        m_owed = m_owed - 1;
        if (m_owed == 0) m_done = 1'b1;
      end else if (start) begin
        m_left = dir;
        if (count == 0) m_done = 1'b1;
        else            m_owed = int'(count);
      end else begin
        case (mode)
          2'b01: m_val = shr(m_val, int'(sin_l));
          2'b10: m_val = shl(m_val, int'(sin_r));
          2'b11: m_val = int'(din);
          default: ;
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("dout_model", int'(dout), m_val);
      check("busy_model", int'(busy), (m_owed > 0) ? 1 : 0);
      check("done_model", int'(done), int'(m_done));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  int dones;
  int first_at, second_at;

  initial begin
    reset = 1'b1; mode = 2'b00; din = '0; sin_l = 1'b0; sin_r = 1'b0;
    start = 1'b0; dir = 1'b0; count = '0;
    tick();
    chk_en = 1'b1;
    // Reset during arbitrary activity
    reset = 1'b0; mode = 2'b11; din = 4'b1001; tick();
    reset = 1'b1; tick();
    check("reset_dout", int'(dout), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    reset = 1'b0;

    // Per-cycle modes
    mode = 2'b11; din = 4'b1011; tick();
    check("load", int'(dout), 'b1011);
    mode = 2'b00; tick(); tick(); tick();
    check("hold", int'(dout), 'b1011);
    mode = 2'b10; sin_r = 1'b1; tick();
    check("shl_mode", int'(dout), 'b0111);
    mode = 2'b11; din = 4'b1011; tick();
    mode = 2'b01; sin_l = 1'b0; tick();
    check("shr_mode", int'(dout), 'b0101);

    // Left burst of 3 from 1011, sin_r=0
    mode = 2'b11; din = 4'b1011; tick();
    mode = 2'b00; sin_r = 1'b0; start = 1'b1; dir = 1'b1; count = 3'd3; tick();
    check("lb_accept_busy", int'(busy), 1);
    check("lb_accept_dout", int'(dout), 'b1011);
    start = 1'b0; tick();
`ifdef SHREG_ROTATE_EN
    check("lb_s1", int'(dout), 'b0111); tick();
    check("lb_s2", int'(dout), 'b1110); tick();
    check("lb_s3", int'(dout), 'b1101);
`else
    check("lb_s1", int'(dout), 'b0110); tick();
    check("lb_s2", int'(dout), 'b1100); tick();
    check("lb_s3", int'(dout), 'b1000);
`endif
    check("lb_done", int'(done), 1);
    check("lb_busy_low", int'(busy), 0);
    tick();
    check("lb_done_clear", int'(done), 0);

    // count=0 burst
    start = 1'b1; count = 3'd0; mode = 2'b11; din = 4'b0101; tick();
    check("c0_done", int'(done), 1);
    check("c0_busy", int'(busy), 0);
`ifdef SHREG_ROTATE_EN
    check("c0_dout", int'(dout), 'b1101);
`else
    check("c0_dout", int'(dout), 'b1000);
`endif
    start = 1'b0; mode = 2'b00; tick();
    check("c0_done_clear", int'(done), 0);

    // Right burst of 5 with load/start driven during it
    start = 1'b1; dir = 1'b0; count = 3'd5; sin_l = 1'b0; tick();
    mode = 2'b11; din = 4'b1111; count = 3'd7; dir = 1'b1;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      dones += int'(done);
    end
    start = 1'b0; mode = 2'b00;
    tick();
    check("r5_done_now", int'(done), 1);
    dones += int'(done);
`ifdef SHREG_ROTATE_EN
    check("r5_dout", int'(dout), 'b1110);
`else
    check("r5_dout", int'(dout), 'b0000);
`endif
    tick(); dones += int'(done);
    tick(); dones += int'(done);
    check("r5_done_once", dones, 1);

    // Reset mid-burst
    mode = 2'b11; din = 4'b1010; tick();
    mode = 2'b00; start = 1'b1; dir = 1'b0; count = 3'd7; sin_l = 1'b1; tick();
    start = 1'b0; tick(); tick();
    reset = 1'b1; tick();
    check("abort_dout", int'(dout), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      dones += int'(done);
    end
    check("abort_no_done", dones, 0);

    // Back-to-back bursts with start held
    mode = 2'b11; din = 4'b0110; tick();
    mode = 2'b00; start = 1'b1; dir = 1'b1; count = 3'd2; sin_r = 1'b1;
    first_at = -1; second_at = -1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (done) begin
        if (first_at < 0) first_at = i;
        else if (second_at < 0) second_at = i;
      end
    end
    check("b2b_first", first_at, 3);
    check("b2b_gap", second_at - first_at, 3);
`ifdef SHREG_ROTATE_EN
    check("b2b_dout", int'(dout), 'b0110);
`else
    check("b2b_dout", int'(dout), 'b1111);
`endif
    start = 1'b0; tick(); tick(); tick(); tick();
    check("b2b_idle", int'(busy), 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shreg_burst.md
# shreg_burst

Parametrised universal shift register with an autonomous burst-shift engine. Per-cycle modes: hold, shift right, shift left, parallel load. A start/busy/done handshake shifts the register a programmed number of positions without further host involvement. Used wherever a plain parallel-in/parallel-out register also needs serialisation, alignment or bit-rotation.

## Interface
Parameters:
- WIDTH, 4: register width in bits (≥2)
- CNT_W, 3: width of the burst count; maximum burst is 2^CNT_W−1 shifts

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous reset, active-high
- mode  in  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
- din  in  WIDTH  parallel load data
- sin_l  in  1  serial input entering at the MSB on a right shift
- sin_r  in  1  serial input entering at the LSB on a left shift
- start  in  1  request a burst; sampled only while idle
- dir  in  1  burst direction, sampled with start: 0 right, 1 left
- count  in  CNT_W  number of burst shifts, sampled with start
- dout  out  WIDTH  register contents
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse when a burst completes

## Operation
- State machine: IDLE, BURST. Registers: data[WIDTH], rem[CNT_W], bdir, done.
- Priority on each edge: reset > BURST activity > start acceptance > mode.
- IDLE, start=0:
  - 00: hold.
  - 01: data ← {sin_l, data[WIDTH−1:1]}.
  - 10: data ← {data[WIDTH−2:0], sin_r}.
  - 11: data ← din.
- IDLE, start=1: mode is ignored and data is unchanged that edge. bdir ← dir.
  - count=0: stay IDLE; done ← 1.
  - Otherwise: rem ← count; state ← BURST.
- BURST:
  - Each edge shifts data one position in bdir and decrements rem.
  - Fill bit follows the macro (see Configuration).
  - The edge where rem goes 1→0 returns to IDLE and sets done ← 1.
  - mode, start, dir, count and din are ignored throughout.
- done is 1 for exactly the cycle after completion and is cleared on every other edge.
- A burst count larger than WIDTH is legal. Shifting continues normally: all-fill without rotation, modulo-WIDTH wrap with rotation.
- busy = (state == BURST), combinational from state.

## Timing
- Reset: dout=0, busy=0, done=0, rem=0, state IDLE, on the first edge with reset high.
- Reset mid-burst aborts the burst. Next cycle dout=0, busy=0, done=0; no done pulse.
- Mode operations take effect one edge after being presented.
- Burst with count=N≥1, accepted at edge E0:
  - busy is high from after E0 through edge E0+N.
  - data shifts at edges E0+1 … E0+N.
  - done=1 and busy=0 in the cycle after E0+N.
- Burst with count=0: done=1 in the cycle after E0, busy never rises, and data is unchanged.
- A start held high during BURST is ignored. It may be accepted on the edge where done is high, giving back-to-back bursts with one idle cycle between them.

## Configuration
- SHREG_ROTATE_EN defined: burst shifts rotate.
  - Right burst: data ← {data[0], data[WIDTH−1:1]}.
  - Left burst: data ← {data[WIDTH−2:0], data[WIDTH−1]}.
- SHREG_ROTATE_EN undefined: burst shifts take the fill bit from sin_l (right) or sin_r (left), sampled each burst edge.
- Per-cycle modes 01/10 always use sin_l/sin_r, with or without the macro.
- The port list is identical in both builds.

## Test plan
All cases use WIDTH=4 and CNT_W=3.
- Reset: assert reset for 1 cycle during arbitrary activity → dout=0000, busy=0, done=0 next cycle.
- Modes: load din=1011 → dout=1011; mode 00 for 3 cycles → 1011; mode 10 with sin_r=1 → 0111; reload 1011, mode 01 with sin_l=0 → 0101.
- Left burst: dout=1011, start with dir=1, count=3, sin_r=0, macro undefined → busy high 3 cycles, dout 0110, 1100, 1000, then done=1 for 1 cycle. Same test with SHREG_ROTATE_EN → 0111, 1110, 1101.
- count=0 plus ignored inputs: start with count=0 → done=1 one cycle, busy=0, dout unchanged. During a count=5 burst, drive mode=11, din=1111 and start=1 → no load and no restart; done fires exactly once after 5 shifts.
- Reset mid-burst: count=7, reset asserted after the 2nd shift → next cycle dout=0000, busy=0, done=0; no later done pulse.
- Back-to-back: hold start=1 through a count=2 burst → second burst accepted on the done cycle; done pulses twice, 3 cycles apart.
